// File: rtl/ntt_core_gf64_ntw_seq_if.sv
// ---------------------------------------------------------------------------
// ntt_core_gf64_ntw_seq_if
// Command / hold / beat-framing bundle of the gf64 column + network sequencer.
// The parameters must match the ones given to ntt_core_gf64_ntw_seq so that
// the field widths line up on both sides.
//
//   cmd_vld / cmd_rdy      batch command handshake
//   cmd_pbs_nb             PBS in the batch
//   cmd_lvl_nb             levels in the batch
//   cmd_pbs_id_base        pbs_id of the first PBS
//   hold                   freeze sequencing for one cycle
//   out_avail              beat valid
//   out_sob/eob            first/last beat of the batch
//   out_sol/eol            first/last beat of a level
//   out_sos/eos            first/last beat of a (level, PBS) chunk
//   out_pbs_id/lvl_id/stg_iter  beat coordinates
//   busy                   sequencer not idle
//   err_cmd                one-cycle pulse on an illegal command
//
// Modports: master drives commands and hold, slave is the sequencer.
// ---------------------------------------------------------------------------
interface ntt_core_gf64_ntw_seq_if #(
    parameter int STG_ITER_NB   = 8,
    parameter int LVL_MAX       = 4,
    parameter int BATCH_PBS_MAX = 8,
    parameter int BPBS_ID_W     = 8
) ();
    localparam int PNB_W = $clog2(BATCH_PBS_MAX + 1);
    localparam int LNB_W = $clog2(LVL_MAX + 1);
    localparam int LID_W = (LVL_MAX > 1) ? $clog2(LVL_MAX) : 1;
    localparam int STG_W = (STG_ITER_NB > 1) ? $clog2(STG_ITER_NB) : 1;

    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [PNB_W-1:0]     cmd_pbs_nb;
    logic [LNB_W-1:0]     cmd_lvl_nb;
    logic [BPBS_ID_W-1:0] cmd_pbs_id_base;
    logic                 hold;
    logic                 out_avail;
    logic                 out_sob;
    logic                 out_eob;
    logic                 out_sol;
    logic                 out_eol;
    logic                 out_sos;
    logic                 out_eos;
    logic [BPBS_ID_W-1:0] out_pbs_id;
    logic [LID_W-1:0]     out_lvl_id;
    logic [STG_W-1:0]     out_stg_iter;
    logic                 busy;
    logic                 err_cmd;

    modport master (
        output cmd_vld, cmd_pbs_nb, cmd_lvl_nb, cmd_pbs_id_base, hold,
        input  cmd_rdy, out_avail, out_sob, out_eob, out_sol, out_eol,
               out_sos, out_eos, out_pbs_id, out_lvl_id, out_stg_iter,
               busy, err_cmd
    );

    modport slave (
        input  cmd_vld, cmd_pbs_nb, cmd_lvl_nb, cmd_pbs_id_base, hold,
        output cmd_rdy, out_avail, out_sob, out_eob, out_sol, out_eol,
               out_sos, out_eos, out_pbs_id, out_lvl_id, out_stg_iter,
               busy, err_cmd
    );
endinterface

// File: rtl/ntt_core_gf64_ntw_seq.sv
// ---------------------------------------------------------------------------
// ntt_core_gf64_ntw_seq
// Generates the per-beat control framing for a batch of PBS flowing through a
// gf64 radix column and its inter-column network. One command is taken at a
// time; beats are emitted one per non-held cycle with loops ordered level
// (outer), PBS (middle), stage iteration (inner). After the eob beat the
// sequencer idles MIN_BATCH_GAP cycles so the ping-pong RAMs can drain.
//
//   clk    clock
//   s_rst  synchronous active-high reset
//   bus    ntt_core_gf64_ntw_seq_if.slave (command, hold, beat framing)
// ---------------------------------------------------------------------------
module ntt_core_gf64_ntw_seq #(
    parameter int STG_ITER_NB   = 8,
    parameter int LVL_MAX       = 4,
    parameter int BATCH_PBS_MAX = 8,
    parameter int BPBS_ID_W     = 8,
    parameter int MIN_BATCH_GAP = 2
) (
    input  logic                          clk,
    input  logic                          s_rst,
    ntt_core_gf64_ntw_seq_if.slave        bus
);
    localparam int PNB_W = $clog2(BATCH_PBS_MAX + 1);
    localparam int LNB_W = $clog2(LVL_MAX + 1);
    localparam int LID_W = (LVL_MAX > 1) ? $clog2(LVL_MAX) : 1;
    localparam int STG_W = (STG_ITER_NB > 1) ? $clog2(STG_ITER_NB) : 1;
    localparam int GAP_W = (MIN_BATCH_GAP > 1) ? $clog2(MIN_BATCH_GAP) : 1;

    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STG_ITER_NB - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_BATCH_GAP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [PNB_W-1:0]     r_pbs_nb;
    logic [LNB_W-1:0]     r_lvl_nb;
    logic [BPBS_ID_W-1:0] r_base;
    logic [LNB_W-1:0]     r_lvl;
    logic [PNB_W-1:0]     r_pbs;
    logic [STG_W-1:0]     r_stg;
    logic [GAP_W-1:0]     r_gap_cnt;

    logic                 r_avail, r_sob, r_eob, r_sol, r_eol, r_sos, r_eos;
    logic [BPBS_ID_W-1:0] r_pbs_id;
    logic [LID_W-1:0]     r_lvl_id;
    logic [STG_W-1:0]     r_stg_iter;
    logic                 r_err;

    logic                 w_run, w_accept, w_cmd_legal, w_start, w_emit;
    logic [PNB_W-1:0]     w_pbs_nb;
    logic [LNB_W-1:0]     w_lvl_nb;
    logic [BPBS_ID_W-1:0] w_base;
    logic [LNB_W-1:0]     w_lvl;
    logic [PNB_W-1:0]     w_pbs;
    logic [STG_W-1:0]     w_stg;
    logic                 w_stg_last, w_pbs_last, w_lvl_last, w_last_beat;
    logic                 w_first;

    // Beat coordinates. Counters always point at the next beat to emit; in
    // IDLE the beat about to be emitted is beat 0 of the incoming command,
    // which is why the first beat can leave on the accept edge.
    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_accept    = (r_state == ST_IDLE) && bus.cmd_vld;
        w_cmd_legal = (bus.cmd_pbs_nb != '0) &&
                      (bus.cmd_pbs_nb <= PNB_W'(BATCH_PBS_MAX)) &&
                      (bus.cmd_lvl_nb != '0) &&
                      (bus.cmd_lvl_nb <= LNB_W'(LVL_MAX));
        w_start     = w_accept && w_cmd_legal;
        w_emit      = w_start || (w_run && !bus.hold);
        w_pbs_nb    = w_run ? r_pbs_nb : bus.cmd_pbs_nb;
        w_lvl_nb    = w_run ? r_lvl_nb : bus.cmd_lvl_nb;
        w_base      = w_run ? r_base   : bus.cmd_pbs_id_base;
        w_lvl       = w_run ? r_lvl    : '0;
        w_pbs       = w_run ? r_pbs    : '0;
        w_stg       = w_run ? r_stg    : '0;
        w_stg_last  = (w_stg == STG_LAST);
        w_pbs_last  = (w_pbs == w_pbs_nb - PNB_W'(1));
        w_lvl_last  = (w_lvl == w_lvl_nb - LNB_W'(1));
        w_last_beat = w_stg_last && w_pbs_last && w_lvl_last;
        w_first     = (w_lvl == '0) && (w_pbs == '0) && (w_stg == '0);
    end

    // Next state. The eob beat can be emitted straight from IDLE when the
    // batch is a single beat, so IDLE and RUN share the end-of-batch test.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (w_emit && w_last_beat)
                    w_state_next = (MIN_BATCH_GAP == 0) ? ST_IDLE : ST_GAP;
                else if (w_start)
                    w_state_next = ST_RUN;
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (s_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Command latch, loop counters, gap counter and registered beat outputs.
    // Non-emitting cycles (hold, gap, idle) drive every beat field to zero.
    always_ff @(posedge clk) begin
        if (s_rst) begin
            r_pbs_nb   <= '0;
            r_lvl_nb   <= '0;
            r_base     <= '0;
            r_lvl      <= '0;
            r_pbs      <= '0;
            r_stg      <= '0;
            r_gap_cnt  <= '0;
            r_avail    <= 1'b0;
            r_sob      <= 1'b0;
            r_eob      <= 1'b0;
            r_sol      <= 1'b0;
            r_eol      <= 1'b0;
            r_sos      <= 1'b0;
            r_eos      <= 1'b0;
            r_pbs_id   <= '0;
            r_lvl_id   <= '0;
            r_stg_iter <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err     <= w_accept && !w_cmd_legal;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
            if (w_start) begin
                r_pbs_nb <= bus.cmd_pbs_nb;
                r_lvl_nb <= bus.cmd_lvl_nb;
                r_base   <= bus.cmd_pbs_id_base;
            end
            if (w_emit) begin
                if (w_last_beat) begin
                    r_lvl <= '0;
                    r_pbs <= '0;
                    r_stg <= '0;
                end else if (w_stg_last) begin
                    r_stg <= '0;
                    if (w_pbs_last) begin
                        r_pbs <= '0;
                        r_lvl <= w_lvl + LNB_W'(1);
                    end else begin
                        r_pbs <= w_pbs + PNB_W'(1);
                        r_lvl <= w_lvl;
                    end
                end else begin
                    r_stg <= w_stg + STG_W'(1);
                    r_pbs <= w_pbs;
                    r_lvl <= w_lvl;
                end
            end
            r_avail    <= w_emit;
            r_sob      <= w_emit && w_first;
            r_eob      <= w_emit && w_last_beat;
            r_sol      <= w_emit && (w_pbs == '0) && (w_stg == '0);
            r_eol      <= w_emit && w_pbs_last && w_stg_last;
            r_sos      <= w_emit && (w_stg == '0);
            r_eos      <= w_emit && w_stg_last;
            r_pbs_id   <= w_emit ? (w_base + BPBS_ID_W'(w_pbs)) : '0;
            r_lvl_id   <= w_emit ? w_lvl[LID_W-1:0] : '0;
            r_stg_iter <= w_emit ? w_stg : '0;
        end
    end

    assign bus.cmd_rdy      = (r_state == ST_IDLE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.out_avail    = r_avail;
    assign bus.out_sob      = r_sob;
    assign bus.out_eob      = r_eob;
    assign bus.out_sol      = r_sol;
    assign bus.out_eol      = r_eol;
    assign bus.out_sos      = r_sos;
    assign bus.out_eos      = r_eos;
    assign bus.out_pbs_id   = r_pbs_id;
    assign bus.out_lvl_id   = r_lvl_id;
    assign bus.out_stg_iter = r_stg_iter;
    assign bus.err_cmd      = r_err;
endmodule

// File: tb/tb_ntt_core_gf64_ntw_seq.sv
// ---------------------------------------------------------------------------
// tb_ntt_core_gf64_ntw_seq
// Directed bench for the gf64 network sequencer. Instance A uses a 2-cycle
// batch gap, instance B a zero gap; both run 4 stage iterations per chunk.
// Expected beat framing comes from hand-written flag tables.
// ---------------------------------------------------------------------------
module tb_ntt_core_gf64_ntw_seq;
    localparam int STG     = 4;
    localparam int LVL_MAX = 4;
    localparam int PBS_MAX = 8;
    localparam int IDW     = 8;
    localparam int PNB_W   = $clog2(PBS_MAX + 1);
    localparam int LNB_W   = $clog2(LVL_MAX + 1);

    // Flag positions for pbs_nb=2, lvl_nb=2, STG=4 (bit k = beat k).
    localparam logic [15:0] SOB_T = 16'h0001;
    localparam logic [15:0] EOB_T = 16'h8000;
    localparam logic [15:0] SOL_T = 16'h0101;
    localparam logic [15:0] EOL_T = 16'h8080;
    localparam logic [15:0] SOS_T = 16'h1111;
    localparam logic [15:0] EOS_T = 16'h8888;

    logic clk = 1'b0;
    logic s_rst;
    int   nChecks = 0;
    int   nFails  = 0;

    ntt_core_gf64_ntw_seq_if #(.STG_ITER_NB(STG), .LVL_MAX(LVL_MAX),
        .BATCH_PBS_MAX(PBS_MAX), .BPBS_ID_W(IDW)) ifA ();
    ntt_core_gf64_ntw_seq_if #(.STG_ITER_NB(STG), .LVL_MAX(LVL_MAX),
        .BATCH_PBS_MAX(PBS_MAX), .BPBS_ID_W(IDW)) ifB ();

    ntt_core_gf64_ntw_seq #(.STG_ITER_NB(STG), .LVL_MAX(LVL_MAX),
        .BATCH_PBS_MAX(PBS_MAX), .BPBS_ID_W(IDW), .MIN_BATCH_GAP(2))
        dutA (.clk(clk), .s_rst(s_rst), .bus(ifA));
    ntt_core_gf64_ntw_seq #(.STG_ITER_NB(STG), .LVL_MAX(LVL_MAX),
        .BATCH_PBS_MAX(PBS_MAX), .BPBS_ID_W(IDW), .MIN_BATCH_GAP(0))
        dutB (.clk(clk), .s_rst(s_rst), .bus(ifB));

    always #5 clk = ~clk;

    // Packed {avail, sob, eob, sol, eol, sos, eos}.
    function automatic logic [6:0] flagsA();
        return {ifA.out_avail, ifA.out_sob, ifA.out_eob, ifA.out_sol,
                ifA.out_eol, ifA.out_sos, ifA.out_eos};
    endfunction

    function automatic logic [6:0] flagsB();
        return {ifB.out_avail, ifB.out_sob, ifB.out_eob, ifB.out_sol,
                ifB.out_eol, ifB.out_sos, ifB.out_eos};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vld, input int pbsNb, input int lvlNb,
                                 input int base, input logic hld);
        ifA.cmd_vld         = vld;
        ifA.cmd_pbs_nb      = PNB_W'(pbsNb);
        ifA.cmd_lvl_nb      = LNB_W'(lvlNb);
        ifA.cmd_pbs_id_base = IDW'(base);
        ifA.hold            = hld;
    endtask

    // Beat k of the reference batch (pbs_nb=2, lvl_nb=2, base=5).
    task automatic checkBeatA(input string tag, input int k);
        logic [6:0] expFlags;
        expFlags = {1'b1, SOB_T[k], EOB_T[k], SOL_T[k], EOL_T[k], SOS_T[k], EOS_T[k]};
        checkOutput($sformatf("%s_flags_b%0d", tag, k), 32'(flagsA()), 32'(expFlags));
        checkOutput($sformatf("%s_pbsid_b%0d", tag, k), 32'(ifA.out_pbs_id),
                    ((k % 8) < 4) ? 32'd5 : 32'd6);
        checkOutput($sformatf("%s_lvl_b%0d", tag, k), 32'(ifA.out_lvl_id), 32'(k / 8));
        checkOutput($sformatf("%s_stg_b%0d", tag, k), 32'(ifA.out_stg_iter), 32'(k % 4));
    endtask

    task automatic waitIdle(input logic selB, input string tag);
        int n = 0;
        while (!(selB ? ifB.cmd_rdy : ifA.cmd_rdy) && n < 100) begin
            nextCycle();
            n++;
        end
        checkOutput(tag, 32'(selB ? ifB.cmd_rdy : ifA.cmd_rdy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int illPbs [4];
        int illLvl [4];
        int idTab  [3];
        logic sawBeat;
        illPbs = '{0, 2, 9, 2};
        illLvl = '{2, LVL_MAX + 1, 1, 0};
        idTab  = '{255, 0, 1};

        // Reset state
        s_rst = 1'b1;
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        ifB.cmd_vld = 1'b0; ifB.cmd_pbs_nb = '0; ifB.cmd_lvl_nb = '0;
        ifB.cmd_pbs_id_base = '0; ifB.hold = 1'b0;
        repeat (3) nextCycle();
        checkOutput("rst_flags", 32'(flagsA()), 32'd0);
        checkOutput("rst_rdy", 32'(ifA.cmd_rdy), 32'd1);
        checkOutput("rst_busy", 32'(ifA.busy), 32'd0);
        checkOutput("rst_err", 32'(ifA.err_cmd), 32'd0);
        checkOutput("rst_pbsid", 32'(ifA.out_pbs_id), 32'd0);
        checkOutput("rst_rdyB", 32'(ifB.cmd_rdy), 32'd1);
        s_rst = 1'b0;
        nextCycle();

        // Reference batch, cmd_vld left high to test the gap
        applyStimulus(1'b1, 2, 2, 5, 1'b0);
        nextCycle();
        for (int k = 0; k < 16; k++) begin
            checkBeatA("t1", k);
            if (k == 0)  checkOutput("t1_busy_run", 32'(ifA.busy), 32'd1);
            if (k == 15) checkOutput("t1_rdy_eob", 32'(ifA.cmd_rdy), 32'd0);
            nextCycle();
        end
        checkOutput("gap1_rdy", 32'(ifA.cmd_rdy), 32'd0);
        checkOutput("gap1_avail", 32'(ifA.out_avail), 32'd0);
        checkOutput("gap1_busy", 32'(ifA.busy), 32'd1);
        nextCycle();
        checkOutput("gap2_rdy", 32'(ifA.cmd_rdy), 32'd1);
        checkOutput("gap2_avail", 32'(ifA.out_avail), 32'd0);
        nextCycle();

        // Second batch: sob here (eob + 3), hold for 3 cycles from beat 5
        for (int t = 0; t < 19; t++) begin
            applyStimulus(1'b0, 2, 2, 5, (t >= 5 && t <= 7));
            if (t <= 5)      checkBeatA("t2", t);
            else if (t <= 8) checkOutput($sformatf("t2_bubble_%0d", t), 32'(flagsA()), 32'd0);
            else             checkBeatA("t2", t - 3);
            nextCycle();
        end
        applyStimulus(1'b0, 2, 2, 5, 1'b0);
        checkOutput("t2_gap_rdy", 32'(ifA.cmd_rdy), 32'd0);
        waitIdle(1'b0, "t2_idle");

        // Illegal commands
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, illPbs[i], illLvl[i], 3, 1'b0);
            nextCycle();
            applyStimulus(1'b0, 0, 0, 0, 1'b0);
            checkOutput($sformatf("ill%0d_err", i), 32'(ifA.err_cmd), 32'd1);
            checkOutput($sformatf("ill%0d_avail", i), 32'(ifA.out_avail), 32'd0);
            checkOutput($sformatf("ill%0d_busy", i), 32'(ifA.busy), 32'd0);
            nextCycle();
            checkOutput($sformatf("ill%0d_err_clr", i), 32'(ifA.err_cmd), 32'd0);
            checkOutput($sformatf("ill%0d_busy2", i), 32'(ifA.busy), 32'd0);
        end

        // pbs_id wrap: base 255, 3 PBS, 1 level
        applyStimulus(1'b1, 3, 1, 255, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            logic [6:0] e;
            e = {1'b1, (k == 0), (k == 11), (k == 0), (k == 11), (k % 4 == 0), (k % 4 == 3)};
            checkOutput($sformatf("wrap_flags_b%0d", k), 32'(flagsA()), 32'(e));
            checkOutput($sformatf("wrap_pbsid_b%0d", k), 32'(ifA.out_pbs_id), 32'(idTab[k / 4]));
            checkOutput($sformatf("wrap_stg_b%0d", k), 32'(ifA.out_stg_iter), 32'(k % 4));
            nextCycle();
        end
        waitIdle(1'b0, "wrap_idle");

        // Reset at beat 9, then a clean restart
        applyStimulus(1'b1, 2, 2, 5, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 2, 2, 5, 1'b0);
        for (int k = 0; k < 9; k++) nextCycle();
        checkBeatA("t6", 9);
        s_rst = 1'b1;
        nextCycle();
        s_rst = 1'b0;
        checkOutput("t6_rst_flags", 32'(flagsA()), 32'd0);
        checkOutput("t6_rst_rdy", 32'(ifA.cmd_rdy), 32'd1);
        checkOutput("t6_rst_busy", 32'(ifA.busy), 32'd0);
        sawBeat = 1'b0;
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            sawBeat = sawBeat | ifA.out_avail;
        end
        checkOutput("t6_no_eob", 32'(sawBeat), 32'd0);
        applyStimulus(1'b1, 2, 2, 5, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 2, 2, 5, 1'b0);
        for (int k = 0; k < 16; k++) begin
            checkBeatA("t6r", k);
            nextCycle();
        end
        waitIdle(1'b0, "t6_idle");

        // Zero gap on instance B: sob right after eob
        ifB.cmd_vld = 1'b1; ifB.cmd_pbs_nb = PNB_W'(1); ifB.cmd_lvl_nb = LNB_W'(1);
        ifB.cmd_pbs_id_base = IDW'(7);
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("g0_pbsid_b%0d", k), 32'(ifB.out_pbs_id), 32'd7);
            checkOutput($sformatf("g0_stg_b%0d", k), 32'(ifB.out_stg_iter), 32'(k));
            if (k == 0)      checkOutput("g0_flags_b0", 32'(flagsB()), 32'b1101010);
            else if (k == 3) checkOutput("g0_flags_b3", 32'(flagsB()), 32'b1010101);
            else             checkOutput($sformatf("g0_flags_b%0d", k), 32'(flagsB()), 32'b1000000);
            if (k == 3) begin
                checkOutput("g0_rdy_eob", 32'(ifB.cmd_rdy), 32'd1);
                checkOutput("g0_busy_eob", 32'(ifB.busy), 32'd0);
            end
            nextCycle();
        end
        ifB.cmd_vld = 1'b0;
        checkOutput("g0_next_sob", 32'(flagsB()), 32'b1101010);
        waitIdle(1'b1, "g0_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/ntt_core_gf64_ntw_seq.md
Name: ntt_core_gf64_ntw_seq

Overview:
- Sequencer that generates the control framing (avail, sob/eob, sol/eol, sos/eos, pbs_id) for a batch of PBS entering a gf64 radix column and its inter-column network.
- Accepts one batch command at a time and emits one control beat per cycle, with level, PBS and stage-iteration loops.
- Honours a hold (stall) input.
- Enforces a minimum idle gap between batches so the network's ping-pong RAMs can drain.

Parameters:
- STG_ITER_NB, 8, beats per (level, PBS) chunk; must be ≥1.
- LVL_MAX, 4, maximum levels per batch.
- BATCH_PBS_MAX, 8, maximum PBS per batch.
- BPBS_ID_W, 8, pbs_id width.
- MIN_BATCH_GAP, 2, idle cycles forced after an eob beat; 0 allowed.

Ports:
- clk  in  1  clock.
- s_rst  in  1  synchronous reset, active-high.
- cmd_vld  in  1  batch command valid.
- cmd_rdy  out  1  command accepted when cmd_vld&cmd_rdy.
- cmd_pbs_nb  in  $clog2(BATCH_PBS_MAX+1)  PBS in batch.
- cmd_lvl_nb  in  $clog2(LVL_MAX+1)  levels in batch.
- cmd_pbs_id_base  in  BPBS_ID_W  pbs_id of first PBS.
- hold  in  1  freeze sequencing this cycle.
- out_avail  out  1  beat valid.
- out_sob, out_eob  out  1 each  first/last beat of batch.
- out_sol, out_eol  out  1 each  first/last beat of a level.
- out_sos, out_eos  out  1 each  first/last beat of a (level, PBS) chunk.
- out_pbs_id  out  BPBS_ID_W  PBS id of beat.
- out_lvl_id  out  $clog2(LVL_MAX)  level index of beat.
- out_stg_iter  out  $clog2(STG_ITER_NB)  iteration index within chunk.
- busy  out  1  state != IDLE.
- err_cmd  out  1  one-cycle pulse on an illegal command.

Behaviour:
- Interface: one clock, clk. Reset s_rst is synchronous and active-high.
- Reset values: all outputs 0 except cmd_rdy=1; state IDLE; all counters 0.
- s_rst asserted mid-batch: the next cycle is IDLE with all outputs at reset values. No eob is emitted for the aborted batch.
- FSM states:
  - IDLE → RUN on a legal accept.
  - RUN → GAP on the edge that registers the eob beat (→ IDLE if MIN_BATCH_GAP=0).
  - GAP → IDLE after MIN_BATCH_GAP cycles.
- cmd_rdy = (state==IDLE). It is combinational from state only and never depends on cmd_vld.
- Illegal command: cmd_pbs_nb==0, cmd_pbs_nb>BATCH_PBS_MAX, cmd_lvl_nb==0, or cmd_lvl_nb>LVL_MAX.
  - The command is accepted and dropped; err_cmd pulses in the next cycle; state stays IDLE.
- Legal accept latches pbs_nb, lvl_nb and base. The first beat (out_avail=1, sob=1) appears in the next cycle. Latency is 1 and all outputs are registered.
- Loop order: level outer, PBS middle, stg_iter inner.
  - Total beats = lvl_nb * pbs_nb * STG_ITER_NB, one per non-held cycle.
- Per-beat flags:
  - sos: stg_iter==0. eos: stg_iter==STG_ITER_NB-1.
  - sol: pbs==0 and stg_iter==0. eol: pbs==pbs_nb-1 and stg_iter==last.
  - sob: first beat of batch. eob: last beat of batch.
  - With STG_ITER_NB=1, sos and eos coincide on every beat.
- out_pbs_id = (base + pbs) mod 2^BPBS_ID_W; wraps silently.
- hold:
  - hold=1 in cycle t → out_avail=0 and all flags 0 in cycle t+1. Counters and state are frozen.
  - hold=0 → the sequence resumes exactly where it stopped.
  - hold is ignored in IDLE and GAP; GAP keeps counting during hold.
  - hold high together with the would-be eob beat delays eob and the GAP entry.
- Gap timing:
  - eob beat at cycle E.
  - With MIN_BATCH_GAP=G: cmd_rdy=0 for cycles E..E+G-1; IDLE at E+G; earliest next sob at E+G+1.
  - With G=0: cmd_rdy=1 at E, so batches run back-to-back.
- busy=1 in RUN and GAP.

Test Plan:
- STG_ITER_NB=4, cmd pbs_nb=2, lvl_nb=2, base=5, no hold → 16 consecutive avail beats starting 1 cycle after accept:
  - sob@0, eob@15; sol@0,8; eol@7,15; sos@0,4,8,12; eos@3,7,11,15.
  - pbs_id 5,5,5,5,6,6,6,6,5,5,5,5,6,6,6,6; lvl_id 0 for beats 0–7, 1 for 8–15.
- Same command with hold high for 3 cycles starting at beat 6 → 3 bubble cycles after beat 5. Beat 6 resumes with stg_iter=2, pbs_id=6. eob occurs 3 cycles later than in the no-hold case.
- MIN_BATCH_GAP=2, second cmd_vld held high → cmd_rdy low for 2 cycles after eob. Next sob appears exactly 3 cycles after the eob cycle. With G=0, sob follows eob on the next cycle.
- cmd_pbs_nb=0, then cmd_lvl_nb=LVL_MAX+1 → err_cmd pulses once per command; out_avail stays 0; busy stays 0.
- base=255, pbs_nb=3, BPBS_ID_W=8 → pbs_id sequence 255, 0, 1 per chunk.
- s_rst asserted at beat 9 of a 16-beat batch → next cycle out_avail=0, all flags 0, cmd_rdy=1, busy=0. A new command then starts cleanly with sob.
